// File: rtl/write_driver_seq.sv
// write_driver_seq: clocked multi-phase bitline write driver for the SRAM column path.
// A request thresholds and latches the column data and mask. The bitlines then step
// through PRECHARGE, DRIVE and RECOVER, and a one-cycle wr_done pulse marks the end.
// All drive outputs are registered, so they change on the edge that enters a phase.
// Optional feature macro: WRITE_DRIVER_NEG_BL_EN enables the negative-bitline write assist.
// With the assist, the low line sits at VSS for the first DRIVE cycle and at VNEG after that.
//
// state | meaning
// IDLE  | ready; all bitlines at VDD; waits for wr_req
// PRECH | bitlines held at VDD for PRE_CYC cycles
// DRIVE | word line on; written columns driven to their data for DRV_CYC cycles
// RECOV | bitlines back at VDD for REC_CYC cycles; wr_done in the last cycle
module write_driver_seq #(
   parameter int  COLS    = 8,
   parameter real VDD     = 1.5,
   parameter real VSS     = 0.0,
   parameter real VTH     = 0.8,
   parameter int  PRE_CYC = 1,
   parameter int  DRV_CYC = 2,
   parameter int  REC_CYC = 1
`ifdef WRITE_DRIVER_NEG_BL_EN
   ,
   parameter real VNEG    = -0.2
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_req,
   output logic            wr_rdy,
   input  real             data_in [0:COLS-1],
   input  logic [COLS-1:0] col_mask,
   output real             bl_wr   [0:COLS-1],
   output real             blb_wr  [0:COLS-1],
   output logic            wl_en,
   output logic            wr_done
);

   localparam int MAX_PD  = (PRE_CYC > DRV_CYC) ? PRE_CYC : DRV_CYC;
   localparam int MAX_CYC = (MAX_PD > REC_CYC) ? MAX_PD : REC_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DRV_CYC - 1);
   localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRECH = 2'd1,
      DRIVE = 2'd2,
      RECOV = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept;
   logic [COLS-1:0]  data_bits;
   logic [COLS-1:0] l_data;
   logic [COLS-1:0] l_mask;
   logic             wl_en_nxt;
   logic             wr_done_nxt;
   real              bl_nxt  [0:COLS-1];
   real              blb_nxt [0:COLS-1];
   real              v_low;

   assign wr_rdy = (state == IDLE);

   // threshold the analog column data; a level exactly at VTH reads as 1
   always_comb begin
      data_bits = '0;
      for (int i = 0; i < COLS; i++) begin
         data_bits[i] = (data_in[i] >= VTH);
      end
   end

   // next-state and phase counter; the counter clears on every state change
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (wr_req) begin
               accept    = 1'b1;
               state_nxt = PRECH;
               cnt_nxt   = '0;
            end
         end
         PRECH: begin
            if (cnt == PRE_LAST) begin
               state_nxt = DRIVE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DRIVE: begin
            if (cnt == DRV_LAST) begin
               state_nxt = RECOV;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RECOV: begin
            if (cnt == REC_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // output levels for the cycle being entered, so the registered outputs line up with the state
   always_comb begin
      wl_en_nxt   = (state_nxt == DRIVE);
      wr_done_nxt = (state_nxt == RECOV) && (cnt_nxt == REC_LAST);
      v_low       = VSS;
`ifdef WRITE_DRIVER_NEG_BL_EN
      if (cnt_nxt != '0) begin
         v_low = VNEG;
      end
`endif
      for (int i = 0; i < COLS; i++) begin
         bl_nxt[i]  = VDD;
         blb_nxt[i] = VDD;
         if ((state_nxt == DRIVE) && l_mask[i]) begin
            if (l_data[i]) begin
               blb_nxt[i] = v_low;
            end else begin
               bl_nxt[i] = v_low;
            end
         end
      end
   end

   // state and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // capture the thresholded data and mask only when a request is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_data <= '0;
         l_mask <= '0;
      end else if (accept) begin
         l_data <= data_bits;
         l_mask <= col_mask;
      end
   end

   // registered drive outputs; reset parks every bitline at VDD with the word line off
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wl_en   <= 1'b0;
         wr_done <= 1'b0;
         for (int i = 0; i < COLS; i++) begin
            bl_wr[i]  <= VDD;
            blb_wr[i] <= VDD;
         end
      end else begin
         wl_en   <= wl_en_nxt;
         wr_done <= wr_done_nxt;
         for (int i = 0; i < COLS; i++) begin
            bl_wr[i]  <= bl_nxt[i];
            blb_wr[i] <= blb_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_write_driver_seq.sv
// tb_write_driver_seq: randomized self-checking bench for write_driver_seq.
// The expected waveform of a write is derived from cycle offsets after acceptance.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_write_driver_seq;

   localparam int  COLS = 8;
   localparam int  PRE  = 1;
   localparam int  DRV  = 2;
   localparam int  REC  = 1;
   localparam int  TOT  = PRE + DRV + REC;
   localparam real VDD  = 1.5;
   localparam real VSS  = 0.0;
   localparam real VTH  = 0.8;
`ifdef WRITE_DRIVER_NEG_BL_EN
   localparam real VLATE = -0.2;
`else
   localparam real VLATE = 0.0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_req;
   logic            wr_rdy;
   logic [COLS-1:0] col_mask;
   logic            wl_en;
   logic            wr_done;
   real             data_in [0:COLS-1];
   real             bl_wr   [0:COLS-1];
   real             blb_wr  [0:COLS-1];

   real             stim    [0:COLS-1];
   int              checks = 0;
   int              errors = 0;
   int              cyc    = 0;
   int              start_cyc;

   write_driver_seq #(
      .COLS(COLS), .VDD(VDD), .VSS(VSS), .VTH(VTH),
      .PRE_CYC(PRE), .DRV_CYC(DRV), .REC_CYC(REC)
   ) dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_rdy(wr_rdy),
      .data_in(data_in), .col_mask(col_mask),
      .bl_wr(bl_wr), .blb_wr(blb_wr), .wl_en(wl_en), .wr_done(wr_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // level on the line a written column pulls low, j cycles after the accepting edge
   function automatic real low_level(input int j);
      if (j == PRE) return VSS;
      return VLATE;
   endfunction

   function automatic real rand_level();
      if ($urandom_range(0, 7) == 0) return VTH;
      return real'($urandom_range(0, 150)) / 100.0;
   endfunction

   task automatic scramble_inputs();
      for (int i = 0; i < COLS; i++) data_in[i] = rand_level();
      col_mask = COLS'($urandom);
   endtask

   // call at a falling edge with the driver idle; returns at the falling edge where it is idle again
   task automatic test_write(input string name, input logic [COLS-1:0] mask, input bit hold_req);
      logic [COLS-1:0] bits;
      bit              in_drv;
      real             e_bl;
      real             e_blb;
      start_cyc = cyc;
      checks++;
      if (wr_rdy !== 1'b1) begin
         errors++;
         $display("FAIL %s rdy_before got %b want 1", name, wr_rdy);
      end
      for (int i = 0; i < COLS; i++) begin
         data_in[i] = stim[i];
         bits[i]    = (stim[i] >= VTH);
      end
      col_mask = mask;
      wr_req   = 1'b1;
      for (int j = 0; j <= TOT; j++) begin
         @(negedge clk);
         if (!hold_req) wr_req = 1'b0;
         in_drv = (j >= PRE) && (j < PRE + DRV);
         checks++;
         if (wl_en !== in_drv) begin
            errors++;
            $display("FAIL %s wl_en j=%0d got %b want %b", name, j, wl_en, in_drv);
         end
         checks++;
         if (wr_done !== (j == TOT - 1)) begin
            errors++;
            $display("FAIL %s wr_done j=%0d got %b want %b", name, j, wr_done, (j == TOT - 1));
         end
         checks++;
         if (wr_rdy !== (j == TOT)) begin
            errors++;
            $display("FAIL %s wr_rdy j=%0d got %b want %b", name, j, wr_rdy, (j == TOT));
         end
         for (int i = 0; i < COLS; i++) begin
            e_bl  = VDD;
            e_blb = VDD;
            if (in_drv && mask[i]) begin
               if (bits[i]) e_blb = low_level(j);
               else         e_bl  = low_level(j);
            end
            checks++;
            if ((bl_wr[i] != e_bl) || (blb_wr[i] != e_blb)) begin
               errors++;
               $display("FAIL %s bitline col=%0d j=%0d got bl=%f blb=%f want bl=%f blb=%f",
                        name, i, j, bl_wr[i], blb_wr[i], e_bl, e_blb);
            end
         end
         if (j < TOT) scramble_inputs();
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      wr_req = 1'b0;
      scramble_inputs();
      #3;
      checks++;
      if ((wr_rdy !== 1'b1) || (wl_en !== 1'b0) || (wr_done !== 1'b0)) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b wl=%b done=%b want 1 0 0", wr_rdy, wl_en, wr_done);
      end
      for (int i = 0; i < COLS; i++) begin
         checks++;
         if ((bl_wr[i] != VDD) || (blb_wr[i] != VDD)) begin
            errors++;
            $display("FAIL reset_bl col=%0d got %f %f want %f", i, bl_wr[i], blb_wr[i], VDD);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ((wr_rdy !== 1'b1) || (wl_en !== 1'b0) || (wr_done !== 1'b0)) begin
         errors++;
         $display("FAIL idle_ctrl got rdy=%b wl=%b done=%b want 1 0 0", wr_rdy, wl_en, wr_done);
      end
   endtask

   task automatic test_basic();
      stim[0] = 1.5; stim[1] = 0.0; stim[2] = 1.2; stim[3] = 0.3;
      stim[4] = 0.8; stim[5] = 0.79; stim[6] = 1.5; stim[7] = 0.0;
      test_write("basic", 8'hFF, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_masked();
      for (int i = 0; i < COLS; i++) stim[i] = rand_level();
      stim[0] = 0.0;
      stim[2] = 1.5;
      test_write("masked", 8'b0000_0101, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_zero_mask();
      for (int i = 0; i < COLS; i++) stim[i] = rand_level();
      test_write("zero_mask", '0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < COLS; i++) stim[i] = rand_level();
         test_write("random", COLS'($urandom), 1'b0);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < COLS; i++) stim[i] = rand_level();
         prev = start_cyc;
         test_write("b2b", COLS'($urandom), (n < 3));
         if (n > 0) begin
            checks++;
            if (start_cyc - prev != TOT + 1) begin
               errors++;
               $display("FAIL b2b_spacing got %0d want %0d", start_cyc - prev, TOT + 1);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_drive();
      scramble_inputs();
      col_mask = 8'hFF;
      wr_req   = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      repeat (PRE) @(negedge clk);
      checks++;
      if (wl_en !== 1'b1) begin
         errors++;
         $display("FAIL mid_drive_wl got %b want 1", wl_en);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ((wl_en !== 1'b0) || (wr_rdy !== 1'b1) || (wr_done !== 1'b0)) begin
         errors++;
         $display("FAIL mid_reset_ctrl got wl=%b rdy=%b done=%b want 0 1 0", wl_en, wr_rdy, wr_done);
      end
      for (int i = 0; i < COLS; i++) begin
         checks++;
         if ((bl_wr[i] != VDD) || (blb_wr[i] != VDD)) begin
            errors++;
            $display("FAIL mid_reset_bl col=%0d got %f %f want %f", i, bl_wr[i], blb_wr[i], VDD);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < TOT + 1; k++) begin
         @(negedge clk);
         checks++;
         if ((wr_done !== 1'b0) || (wr_rdy !== 1'b1)) begin
            errors++;
            $display("FAIL post_reset_idle k=%0d got done=%b rdy=%b want 0 1", k, wr_done, wr_rdy);
         end
      end
      for (int i = 0; i < COLS; i++) stim[i] = rand_level();
      test_write("after_reset", COLS'($urandom), 1'b0);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < COLS; i++) begin
         data_in[i] = 0.0;
         stim[i]    = 0.0;
      end
      col_mask  = '0;
      wr_req    = 1'b0;
      rst       = 1'b0;
      start_cyc = 0;
      test_reset();
      test_basic();
      test_masked();
      test_zero_mask();
      test_random();
      test_back_to_back();
      test_reset_mid_drive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
